// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_fetch_queue.sv
// fetch_queue: circular FIFO of fetched words; flush empties it and wins over push
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  // pointer and occupancy update; power-of-2 depth lets pointers wrap naturally
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
    rd_d = flush ? '0 : rd_q + AW'(pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    head = mem_q[rd_q];
    count = count_q;
  end
  // storage and pointer registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch PC, one-outstanding req/ack imem port, fetch queue and branch redirect
module if_stage
  import if_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] pc_out,
  output logic [31:0] instruction
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [AW:0] count, occ_pop, occ_push;
  logic push, pop;
  fetch_entry_t head, din;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // state, fetch PC and the address held for a request being dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end

  // next state: launch a request only when a queue slot is guaranteed free
  always_comb begin
    occ_pop = count - (AW+1)'(pop);
    occ_push = occ_pop + (AW+1)'(push);
    state_d = state_q == DROP ? (imem_ack ? REQ : DROP)
            : state_q == REQ  ? (branch_taken ? (imem_ack ? REQ : DROP)
                                              : (!imem_ack || occ_push < FULL) ? REQ : IDLE)
            : (!branch_taken && occ_pop < FULL) ? REQ : IDLE;
    fetch_pc_d = branch_taken ? branch_addr : push ? fetch_pc_q + PC_STEP : fetch_pc_q;
    addr_d = state_q == DROP ? addr_q : fetch_pc_q;
  end

  // memory port, queue control and downstream outputs (zeroed while empty)
  always_comb begin
    imem_req = state_q != IDLE;
    imem_addr = state_q == DROP ? addr_q : fetch_pc_q;
    valid = count != '0;
    push = state_q == REQ && imem_ack && !branch_taken;
    pop = valid && !freeze && !branch_taken;
    din = '{pc_plus4: fetch_pc_q + PC_STEP, instr: imem_rdata};
    pc_out = valid ? head.pc_plus4 : '0;
    instruction = valid ? head.instr : '0;
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch timing, freeze, redirect, wrap and async reset
module tb_if_stage;
  localparam logic [31:0] K = 32'h1357_0000;
  logic clk = 1'b0;
  logic rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic imem_req, imem_ack, valid;
  logic [31:0] imem_addr, imem_rdata, pc_out, instruction;
  logic req2, ack2, valid2;
  logic [31:0] addr2, rdata2, pc2, instr2;
  int lat, wcnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid(valid),
    .pc_out(pc_out), .instruction(instruction)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .valid(valid2),
    .pc_out(pc2), .instruction(instr2)
  );

  // memory model: ack after lat waiting cycles, word = address + K
  always @(posedge clk or negedge rst)
    if (!rst) wcnt <= 0;
    else wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
  assign imem_ack = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr + K;
  assign ack2 = req2;
  assign rdata2 = addr2 + K;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; lat = 0;
    tick(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    rst = 1'b1;
    tick(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("first_valid", 32'(valid), 32'd0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
    for (int k = 2; k <= 6; k++) begin
      tick(1);
      chk("stream_valid", 32'(valid), 32'd1);
      chk("stream_pc", pc_out, 32'(4 * (k - 1)));
      chk("stream_instr", instruction, 32'(4 * (k - 2)) + K);
      chk("stream_addr", imem_addr, 32'(4 * (k - 1)));
      chk("wrap_addr", addr2, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
      chk("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
    end
    rst = 1'b0; lat = 2;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("lat_req", 32'(imem_req), 32'd1);
    chk("lat_ack0", 32'(imem_ack), 32'd0);
    tick(1);
    freeze = 1'b1;
    tick(1);
    chk("lat_ack", 32'(imem_ack), 32'd1);
    tick(1);
    chk("frz_pc1", pc_out, 32'd4);
    chk("frz_addr1", imem_addr, 32'd4);
    tick(3);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("frz_pc_hold", pc_out, 32'd4);
    chk("frz_instr_hold", instruction, K);
    freeze = 1'b0;
    tick(1);
    chk("resume_pc", pc_out, 32'd8);
    chk("resume_instr", instruction, 32'd4 + K);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'd8);
    tick(1);
    chk("drain_valid", 32'(valid), 32'd0);
    tick(2);
    chk("next_pc", pc_out, 32'd12);
    chk("next_instr", instruction, 32'd8 + K);
    chk("wait_addr", imem_addr, 32'd12);
    chk("wait_ack", 32'(imem_ack), 32'd0);
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick(1);
    branch_taken = 1'b0;
    chk("drop_valid", 32'(valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'd12);
    tick(1);
    chk("drop_ack", 32'(imem_ack), 32'd1);
    chk("drop_addr_ack", imem_addr, 32'd12);
    tick(1);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", 32'(valid), 32'd0);
    tick(3);
    chk("redir_pc", pc_out, 32'h104);
    chk("redir_instr", instruction, 32'h100 + K);
    freeze = 1'b1;
    tick(1);
    chk("frz2_pc", pc_out, 32'h104);
    tick(1);
    chk("coin_ack", 32'(imem_ack), 32'd1);
    chk("coin_addr_old", imem_addr, 32'h104);
    branch_taken = 1'b1; branch_addr = 32'h200;
    tick(1);
    branch_taken = 1'b0;
    chk("coin_valid", 32'(valid), 32'd0);
    chk("coin_pc", pc_out, 32'd0);
    chk("coin_instr", instruction, 32'd0);
    chk("coin_addr", imem_addr, 32'h200);
    freeze = 1'b0;
    tick(3);
    chk("coin_pc2", pc_out, 32'h204);
    chk("coin_instr2", instruction, 32'h200 + K);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pc", pc_out, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
